// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word/address widths, fetch FSM states and the
// fetch queue entry layout used between the fetch stage and decode.
package cpu_pkg;

   localparam int unsigned WORD_SIZE     = 32;
   localparam int unsigned ADDR_WIDTH    = 8;
   localparam int unsigned FETCH_CNT_W   = 16;
   localparam int unsigned QCOUNT_W      = 2;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [WORD_SIZE-1:0]  instr;
      logic [ADDR_WIDTH-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode handshake bundle.
//   out_valid  fetch -> decode  head entry valid
//   out_ready  decode -> fetch  decode accepts head
//   out_instr  fetch -> decode  head instruction word
//   out_pc     fetch -> decode  address the head was fetched from
interface instr_fetch_unit_if;

   logic                             out_valid;
   logic                             out_ready;
   logic [cpu_pkg::WORD_SIZE-1:0]    out_instr;
   logic [cpu_pkg::ADDR_WIDTH-1:0]   out_pc;

   modport master (
      output out_valid,
      output out_instr,
      output out_pc,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_instr,
      input  out_pc,
      output out_ready
   );

endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Two-entry fetch FIFO with flush.
//   clk, rst  clock, synchronous active-low reset
//   push/din  enqueue an entry (caller never pushes when full without pop)
//   pop       dequeue head (only meaningful while valid)
//   flush     drop all entries; beats push/pop
//   count     number of held entries (0..2)
//   valid     count != 0
//   head      oldest entry; holds its last value while empty
module fetch_queue
   import cpu_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic                flush,
   input  fetch_entry_t        din,
   output logic [QCOUNT_W-1:0] count,
   output logic                valid,
   output fetch_entry_t        head
);

   fetch_entry_t slot0_q;   // head
   fetch_entry_t slot1_q;   // second entry
   logic [QCOUNT_W-1:0] count_q;

   // Slot 0 is always the head, so the decode-facing outputs come straight
   // from a register and stay put while decode stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= '0;
      end else if (flush) begin
         count_q <= '0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count_q == QCOUNT_W'(0)) begin
                  slot0_q <= din;
                  count_q <= QCOUNT_W'(1);
               end else if (count_q == QCOUNT_W'(1)) begin
                  slot1_q <= din;
                  count_q <= QCOUNT_W'(2);
               end
            end
            2'b01: begin
               // Emptying from one entry leaves slot 0 untouched (holds last value).
               if (count_q == QCOUNT_W'(2)) slot0_q <= slot1_q;
               if (count_q != QCOUNT_W'(0)) count_q <= count_q - QCOUNT_W'(1);
            end
            2'b11: begin
               if (count_q == QCOUNT_W'(2)) begin
                  slot0_q <= slot1_q;
                  slot1_q <= din;
               end else begin
                  slot0_q <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign count = count_q;
   assign valid = (count_q != QCOUNT_W'(0));
   assign head  = slot0_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage in front of the unified CPU memory.
//   clk, rst            clock, synchronous active-low reset
//   instr_read_address  registered PC driven to memory
//   instr_instruction   combinational memory read data for that address
//   redirect_valid/_target  branch/jump redirect, flushes the queue
//   halt_req            level; stops new fetches, queue keeps draining
//   out_if              {instr, pc} valid/ready handshake to decode
//   fetch_count         saturating count of queue pushes since reset
//   idle                halted with an empty queue
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [ADDR_WIDTH-1:0]  instr_read_address,
   input  logic [WORD_SIZE-1:0]   instr_instruction,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_target,
   input  logic                   halt_req,
   instr_fetch_unit_if.master     out_if,
   output logic [FETCH_CNT_W-1:0] fetch_count,
   output logic                   idle
);

   fetch_state_e            state_q;
   logic [ADDR_WIDTH-1:0]   pc_q;
   logic [FETCH_CNT_W-1:0]  fetch_count_q;
   logic                    idle_q;

   logic                    push_c;
   logic                    pop_c;
   logic                    q_valid;
   logic [QCOUNT_W-1:0]     q_count;
   logic [QCOUNT_W-1:0]     q_count_next_c;
   fetch_state_e            state_next_c;
   fetch_entry_t            push_entry;
   fetch_entry_t            q_head;

   // Push/pop decisions and the queue occupancy the next cycle will see.
   always_comb begin
      pop_c          = q_valid && out_if.out_ready;
      push_c         = (state_q == RUN) && !halt_req && !redirect_valid &&
                       ((q_count < QCOUNT_W'(2)) || pop_c);
      state_next_c   = halt_req ? HALTED : RUN;
      q_count_next_c = q_count;
      if (redirect_valid)      q_count_next_c = '0;
      else if (push_c && !pop_c) q_count_next_c = q_count + QCOUNT_W'(1);
      else if (!push_c && pop_c) q_count_next_c = q_count - QCOUNT_W'(1);
   end

   assign push_entry = '{instr: instr_instruction, pc: pc_q};

   // PC, fetch state, push counter and idle flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= RUN;
         pc_q          <= RESET_PC;
         fetch_count_q <= '0;
         idle_q        <= 1'b0;
      end else begin
         state_q <= state_next_c;
         idle_q  <= (state_next_c == HALTED) && (q_count_next_c == QCOUNT_W'(0));
         if (redirect_valid) pc_q <= redirect_target;
         else if (push_c)    pc_q <= pc_q + ADDR_WIDTH'(1);
         if (push_c && (fetch_count_q != '1))
            fetch_count_q <= fetch_count_q + FETCH_CNT_W'(1);
      end
   end

   fetch_queue u_fetch_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .pop   (pop_c),
      .flush (redirect_valid),
      .din   (push_entry),
      .count (q_count),
      .valid (q_valid),
      .head  (q_head)
   );

   assign instr_read_address = pc_q;
   assign fetch_count        = fetch_count_q;
   assign idle               = idle_q;
   assign out_if.out_valid   = q_valid;
   assign out_if.out_instr   = q_head.instr;
   assign out_if.out_pc      = q_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table-driven vectors plus a scoreboard model.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic [7:0]  instr_read_address;
   logic [31:0] instr_instruction;
   logic        redirect_valid;
   logic [7:0]  redirect_target;
   logic        halt_req;
   logic [15:0] fetch_count;
   logic        idle;

   instr_fetch_unit_if dec_if ();

   instr_fetch_unit #(.RESET_PC(8'h00)) dut (
      .clk                (clk),
      .rst                (rst),
      .instr_read_address (instr_read_address),
      .instr_instruction  (instr_instruction),
      .redirect_valid     (redirect_valid),
      .redirect_target    (redirect_target),
      .halt_req           (halt_req),
      .out_if             (dec_if),
      .fetch_count        (fetch_count),
      .idle               (idle)
   );

   logic [31:0] mem [256];
   assign instr_instruction = mem[instr_read_address];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic [7:0]  pc;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  m_pc;
   logic        m_halted;
   logic [15:0] m_fc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, score any handshake, advance model, compare.
   task automatic step(input logic r, input logic rv, input logic [7:0] tg,
                       input logic h, input logic rd);
      int   sz;
      logic mpop;
      logic mpush;
      exp_t e;
      exp_t nw;
      rst             = r;
      redirect_valid  = rv;
      redirect_target = tg;
      halt_req        = h;
      dec_if.out_ready = rd;
      #1;
      sz   = sb.size();
      mpop = r && rd && (sz != 0);
      if (mpop) begin
         e = sb.pop_front();
         chk("pop_valid", 32'(dec_if.out_valid), 32'd1);
         chk("pop_instr", dec_if.out_instr, e.instr);
         chk("pop_pc", 32'(dec_if.out_pc), 32'(e.pc));
      end
      mpush    = r && !m_halted && !h && !rv && ((sz < 2) || mpop);
      nw.instr = mem[m_pc];
      nw.pc    = m_pc;
      @(posedge clk);
      #1;
      if (!r) begin
         sb.delete();
         m_pc     = 8'h00;
         m_halted = 1'b0;
         m_fc     = 16'h0000;
      end else begin
         if (rv) begin
            sb.delete();
            m_pc = tg;
         end else if (mpush) begin
            sb.push_back(nw);
            m_pc = m_pc + 8'd1;
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
         end
         m_halted = h;
      end
      chk("valid", 32'(dec_if.out_valid), 32'(sb.size() != 0));
      chk("read_addr", 32'(instr_read_address), 32'(m_pc));
      chk("fetch_count", 32'(fetch_count), 32'(m_fc));
      chk("idle", 32'(idle), 32'(m_halted && (sb.size() == 0)));
      if (sb.size() != 0) begin
         chk("head_instr", dec_if.out_instr, sb[0].instr);
         chk("head_pc", 32'(dec_if.out_pc), 32'(sb[0].pc));
      end
   endtask

   typedef struct {
      logic        rst;
      logic        ready;
      logic        exp_valid;
      logic [7:0]  exp_pc;
      logic [7:0]  exp_addr;
      logic [15:0] exp_fc;
   } vec_t;

   vec_t tbl[13];

   initial begin
      rst = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = 8'h00;
      halt_req = 1'b0;
      dec_if.out_ready = 1'b0;
      m_pc = 8'h00;
      m_halted = 1'b0;
      m_fc = 16'h0000;
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

      // rst, ready, exp_valid, exp_pc, exp_addr, exp_fc
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 16'd0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 16'd0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h01, 16'd1};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 16'd2};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h02, 8'h03, 16'd3};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h03, 8'h04, 16'd4};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'd0};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 16'd1};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h02, 16'd2};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h02, 16'd2};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h02, 16'd2};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 8'h01, 8'h03, 16'd3};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h02, 8'h04, 16'd4};

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].rst, 1'b0, 8'h00, 1'b0, tbl[i].ready);
         chk("tbl_valid", 32'(dec_if.out_valid), 32'(tbl[i].exp_valid));
         chk("tbl_pc", 32'(dec_if.out_pc), 32'(tbl[i].exp_pc));
         chk("tbl_addr", 32'(instr_read_address), 32'(tbl[i].exp_addr));
         chk("tbl_fc", 32'(fetch_count), 32'(tbl[i].exp_fc));
         if (tbl[i].exp_valid)
            chk("tbl_instr", dec_if.out_instr, mem[tbl[i].exp_pc]);
         else
            chk("tbl_rst_instr", dec_if.out_instr, 32'h0);
      end

      // Redirect while the queue is full.
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h80, 1'b0, 1'b0);
      chk("redir_flush_valid", 32'(dec_if.out_valid), 32'd0);
      chk("redir_addr", 32'(instr_read_address), 32'h80);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("redir_head_pc", 32'(dec_if.out_pc), 32'h80);
      chk("redir_head_instr", dec_if.out_instr, 32'hC0DE_0080);

      // Redirect near the top of memory; PC wraps 0xFF -> 0x00.
      step(1'b1, 1'b1, 8'hFE, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         logic [7:0] want;
         want = 8'hFE + 8'(k);
         step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
         chk("wrap_pc", 32'(dec_if.out_pc), 32'(want));
      end

      // Halt for three cycles: queue drains, no pushes, idle rises.
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      chk("halt_idle", 32'(idle), 32'd1);
      chk("halt_valid", 32'(dec_if.out_valid), 32'd0);
      chk("halt_addr", 32'(instr_read_address), 32'h02);
      chk("halt_fc", 32'(fetch_count), 32'd9);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("resume_idle", 32'(idle), 32'd0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("resume_pc", 32'(dec_if.out_pc), 32'h02);
      chk("resume_valid", 32'(dec_if.out_valid), 32'd1);

      // Reset while full and halted, with other inputs active.
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_idle", 32'(idle), 32'd0);
      step(1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
      chk("rst_valid", 32'(dec_if.out_valid), 32'd0);
      chk("rst_addr", 32'(instr_read_address), 32'h00);
      chk("rst_pc", 32'(dec_if.out_pc), 32'h00);
      chk("rst_instr", dec_if.out_instr, 32'h0);
      chk("rst_fc", 32'(fetch_count), 32'd0);
      chk("rst_idle", 32'(idle), 32'd0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("post_rst_run_pc", 32'(dec_if.out_pc), 32'h00);
      chk("post_rst_run_valid", 32'(dec_if.out_valid), 32'd1);
      chk("post_rst_instr", dec_if.out_instr, 32'h11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the unified CPU memory: drives the memory's 8-bit instruction read address, captures the combinationally returned instruction word into a 2-entry fetch queue, and presents {instruction, pc} to decode over a valid/ready handshake. Handles sequential PC advance with wrap-around, branch/jump redirect with queue flush, and a halt request that stops fetching while letting the queue drain.

## Interface
- WORD_SIZE, 32, instruction word width; equals memory word width
- ADDR_WIDTH, 8, word address width; memory is 256 words, word-addressed
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-low (rst==0 on a posedge resets)
- instr_read_address  out  ADDR_WIDTH  to memory; always equals current pc
- instr_instruction  in  WORD_SIZE  from memory; combinational read of instr_read_address
- redirect_valid  in  1  load redirect_target into pc and flush queue
- redirect_target  in  ADDR_WIDTH  new fetch address
- halt_req  in  1  level; while high, no new fetches
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  WORD_SIZE  head instruction
- out_pc  out  ADDR_WIDTH  address the head instruction was fetched from
- fetch_count  out  16  number of queue pushes since reset, saturates at 16'hFFFF
- idle  out  1  state HALTED and queue empty

## Operation
- States: RUN, HALTED. Reset -> RUN.
- RUN -> HALTED on the posedge where halt_req==1; HALTED -> RUN on the posedge where halt_req==0.
- Push: state RUN, halt_req==0, redirect_valid==0, and (count<2 or pop this cycle). Pushes {instr_instruction, pc}; pc <= pc+1 mod 2^ADDR_WIDTH (255 -> 0).
- When push is not allowed (queue full without pop, halted, halt_req high), pc holds.
- Pop: out_valid && out_ready. Removes head; next entry becomes head.
- Simultaneous push and pop with count==2: allowed, count stays 2, order preserved.
- Redirect (highest priority, any state): pc <= redirect_target, count <= 0, no push that cycle. A pop handshake in the same cycle counts as completed by decode; entry is discarded with the flush. State transition on halt_req still applies.
- out_valid = (count != 0); out_instr/out_pc reflect head entry; when empty, they hold their last values (zero after reset); decode must ignore them.
- fetch_count increments by 1 per push, saturating.
- Handshake rule: while out_valid==1 and out_ready==0, out_instr/out_pc stable unless redirect_valid flushes.

## Timing
- Reset values: pc=RESET_PC, instr_read_address=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, fetch_count=0, idle=0, state=RUN.
- Reset mid-operation: all of the above on that posedge regardless of other inputs; queue contents lost.
- Fetch latency: instruction at pc visible on out_instr one cycle after the push cycle.
- Steady state with out_ready==1: one instruction per cycle.
- Redirect latency: redirect on cycle N -> instr_read_address==target in cycle N+1 -> out_valid with out_pc==target in cycle N+2.
- halt_req high in cycle N: no push in N; idle rises once queue empties (earliest N+1).
- instr_read_address is a direct register output; no combinational path from any input to it.

## Structure
- Shared package cpu_pkg: WORD_SIZE, ADDR_WIDTH, fetch state enum {RUN, HALTED}, queue entry struct {instr, pc}.
- One sub-module: fetch_queue (2-entry FIFO with push/pop/flush, count, head output). The top holds pc, state, fetch_count.

## Test plan
- Reset with RESET_PC=0, memory words 0..3 = 0x11,0x22,0x33,0x44, out_ready=1 -> out_pc 0,1,2,3 on consecutive cycles with matching instr; fetch_count==4 after 4 pushes.
- out_ready=0 from reset -> queue fills to 2 (out_pc==0 held stable), instr_read_address stops at 2; release out_ready -> 0,1,2 delivered in order, no loss or duplicate.
- Redirect to 0x80 while queue holds 2 entries -> out_valid==0 next cycle, out_pc==0x80 two cycles after redirect.
- Redirect to 0xFE, out_ready=1 -> out_pc sequence 0xFE, 0xFF, 0x00, 0x01 (wrap).
- halt_req high 3 cycles with out_ready=1 -> no new pushes, queue drains, idle==1; halt_req low -> fetch resumes from held pc, idle==0.
- Assert rst=0 while queue full and halted -> next cycle all outputs at reset values, state RUN, pc==RESET_PC.
